fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
Instruction fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the program counter and drives the combinational instruction-memory address. It buffers fetched instructions, each paired with its PC+4, in a small FIFO, and presents them to decode through a valid/ready handshake. A redirect input from branch/jump resolution flushes the queue and restarts fetch at the target.

Parameters:
RESET_PC, 32'd100, PC value loaded on reset.
DEPTH, 4, queue entries; power of two, minimum 2.
AW, $clog2(DEPTH), queue pointer width (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_addr  output  32  instruction memory address; equals pc
imem_rdata  input  32  instruction word at imem_addr, same-cycle combinational
redirect  input  1  taken branch/jump; flush and reload PC
redirect_target  input  32  new fetch address, valid when redirect=1
out_valid  output  1  queue head holds an instruction
out_ready  input  1  decode/IF-ID accepts head this cycle
out_instr  output  32  head instruction word; 32'h0 (NOP) when empty
out_pc4  output  32  head instruction address + 4; 32'h0 when empty
queue_count  output  AW+1  occupied entries, 0..DEPTH
fetch_count  output  32  total instructions pushed since reset, wraps modulo 2^32

Behaviour:
- Reset: on a rising edge with rst_n=0, pc<=RESET_PC, rd_ptr=wr_ptr=0, count=0, fetch_count=0.
- Reset outputs: out_valid=0, out_instr=0, out_pc4=0, queue_count=0, imem_addr=RESET_PC. Queue storage contents are don't-care.
- Reset mid-operation discards all queued entries and any pending redirect; reset has priority over every other input.
- Definitions:
  - pop = out_valid & out_ready & !redirect
  - push = !redirect & (count<DEPTH | pop)
- Simultaneous push and pop while full is allowed; count is unchanged.
- Push: entry[wr_ptr]<={imem_rdata, pc+4}; wr_ptr++ (wraps at DEPTH); pc<=pc+4; fetch_count++.
- Pop: rd_ptr++ (wraps at DEPTH).
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Full (count=DEPTH, no pop): pc holds; imem_addr is stable; no push occurs.
- Empty (count=0): out_valid=0; out_ready is ignored.
- Redirect takes priority over push and pop:
  - count<=0, rd_ptr<=wr_ptr<=0, pc<={redirect_target[31:2],2'b00}.
  - No push that cycle; fetch_count unchanged.
  - A head presented with out_valid=1 and out_ready=1 in a redirect cycle is discarded. It is not a completed transfer.
- Misaligned redirect target: low two bits forced to zero silently.
- Latency from reset release: the first edge with rst_n=1 pushes the RESET_PC instruction; out_valid=1 in the following cycle.
- Latency from redirect: at edge N, with redirect=1, the flush happens. At edge N+1 the target is pushed. out_valid=1 with the target instruction after edge N+1, i.e. 2 cycles after redirect is asserted.
- Outputs out_valid, out_instr, out_pc4 and queue_count are combinational from registered state only. There is no combinational path from imem_rdata or out_ready to any output.
- PC arithmetic is 32-bit unsigned and wraps from 32'hFFFFFFFC to 32'h0.

Test Plan:
- Reset then steady flow: rst_n=0 for 2 cycles, then 1, out_ready=1, imem returns addr^32'hA5A5A5A5 -> out_valid=1 from 2nd cycle after release; out_pc4 sequence 104, 108, 112…; one instruction per cycle; queue_count stays at 1.
- Fill to full: out_ready=0 for 8 cycles after reset release -> queue_count reaches 4 and holds; imem_addr=116 (pc=116) stays constant; fetch_count=4. Then out_ready=1 -> entries 100..112 drain in order, then fetching resumes at 116.
- Full with simultaneous push/pop: queue full, out_ready=1 for one cycle -> queue_count stays 4, fetch_count+1, pc advances by 4.
- Redirect with full queue and out_ready=1: redirect_target=32'h0000_0203 -> next cycle queue_count=0, out_valid=0, imem_addr=32'h200; a cycle later out_pc4=32'h204. The discarded head is not consumed and fetch_count does not increment in the redirect cycle.
- Mid-operation reset: queue holding 3 entries, pc=112, rst_n=0 for one edge -> queue_count=0, fetch_count=0, imem_addr=100; a redirect asserted in the same cycle is ignored.
- PC wrap: redirect to 32'hFFFFFFFC, out_ready=1 -> out_pc4=0 for that instruction; next imem_addr=0.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the PC and queues {instr, pc+4} pairs for decode; head visible 1 cycle after push.
// Backpressure: fetch stalls (pc holds) while the queue is full and decode does not accept.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'd100,
  parameter int          DEPTH    = 4,
  parameter int          AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc4,
  output logic [AW:0]   queue_count,
  output logic [31:0]   fetch_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fq_entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   fetch_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  fq_entry_t     mem [DEPTH];
  fq_entry_t     head;
  logic          pop;
  logic          push;

  assign imem_addr   = pc;
  assign queue_count = count;
  assign fetch_count = fetch_cnt;
  assign head        = mem[rd_ptr];
  assign out_valid   = (count != '0);

  // A head offered during a redirect is dropped, so it never counts as popped.
  assign pop  = out_valid & out_ready & ~redirect;
  assign push = ~redirect & ((count < FULL) | pop);

  always_comb begin
    out_instr = '0;
    out_pc4   = '0;
    if (out_valid) begin
      out_instr = head.instr;
      out_pc4   = head.pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_cnt <= '0;
    end else if (redirect) begin
      pc     <= redirect_target & 32'hFFFF_FFFC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        pc        <= pc + 32'd4;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{instr: imem_rdata, pc4: pc + 32'd4};
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_queue_unit;

  localparam int          DEPTH = 4;
  localparam int          AW    = 2;
  localparam logic [31:0] RPC   = 32'd100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc4;
  logic [AW:0]   queue_count;
  logic [31:0]   fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_queue_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc4         (out_pc4),
    .queue_count     (queue_count),
    .fetch_count     (fetch_count)
  );

  // Reference model: queue of {instr, pc4}, fetch PC and push counter.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  bit          m_known = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs after negedge, compare against the model, then advance the model at posedge.
  task automatic step(input logic r_n, input logic rdir, input logic [31:0] tgt, input logic rdy);
    bit          take;
    logic [63:0] hd;
    @(negedge clk);
    rst_n           = r_n;
    redirect        = rdir;
    redirect_target = tgt;
    out_ready       = rdy;
    #1;
    if (m_known) begin
      hd = (mq.size() > 0) ? mq[0] : 64'h0;
      chk("imem_addr",   imem_addr,   m_pc);
      chk("queue_count", {29'h0, queue_count}, mq.size());
      chk("out_valid",   {31'h0, out_valid}, {31'h0, mq.size() > 0});
      chk("out_instr",   out_instr,   hd[63:32]);
      chk("out_pc4",     out_pc4,     hd[31:0]);
      chk("fetch_count", fetch_count, m_fc);
    end
    @(posedge clk);
    if (!r_n) begin
      mq.delete();
      m_pc    = RPC;
      m_fc    = 32'h0;
      m_known = 1;
    end else if (m_known) begin
      if (rdir) begin
        mq.delete();
        m_pc = {tgt[31:2], 2'b00};
      end else begin
        take = (mq.size() > 0) && rdy;
        if (take) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          mq.push_back({mem_word(m_pc), m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
          m_fc = m_fc + 32'd1;
        end
      end
    end
  endtask

  // Observe registered outputs just after the edge that step() ended on.
  task automatic peek();
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_target = 32'h0; out_ready = 1'b0;

    // Reset then steady flow
    do_reset(2);
    peek();
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc4",   out_pc4,   32'h0);
    chk("rst_addr",  imem_addr, RPC);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    peek();
    chk("flow_valid", {31'h0, out_valid}, 32'h1);
    chk("flow_pc4_0", out_pc4, 32'd104);
    chk("flow_instr", out_instr, 32'd100 ^ 32'hA5A5_A5A5);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    peek();
    chk("flow_pc4_1", out_pc4, 32'd108);
    chk("flow_cnt",   {29'h0, queue_count}, 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    peek();
    chk("flow_pc4_2", out_pc4, 32'd112);

    // Fill to full, then push+pop while full
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    peek();
    chk("full_cnt",  {29'h0, queue_count}, 32'd4);
    chk("full_addr", imem_addr, 32'd116);
    chk("full_fc",   fetch_count, 32'd4);
    chk("full_head", out_pc4, 32'd104);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    peek();
    chk("pp_cnt",  {29'h0, queue_count}, 32'd4);
    chk("pp_fc",   fetch_count, 32'd5);
    chk("pp_addr", imem_addr, 32'd120);
    chk("pp_head", out_pc4, 32'd108);

    // Redirect with full queue and ready asserted, misaligned target
    step(1'b1, 1'b1, 32'h0000_0203, 1'b1);
    peek();
    chk("rd_cnt",   {29'h0, queue_count}, 32'd0);
    chk("rd_valid", {31'h0, out_valid}, 32'h0);
    chk("rd_addr",  imem_addr, 32'h200);
    chk("rd_fc",    fetch_count, 32'd5);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    peek();
    chk("rd_valid2", {31'h0, out_valid}, 32'h1);
    chk("rd_pc4",    out_pc4, 32'h204);

    // Mid-operation reset with a redirect in the same cycle
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    peek();
    chk("mr_pre_cnt",  {29'h0, queue_count}, 32'd3);
    chk("mr_pre_addr", imem_addr, 32'd112);
    step(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    peek();
    chk("mr_cnt",  {29'h0, queue_count}, 32'd0);
    chk("mr_fc",   fetch_count, 32'd0);
    chk("mr_addr", imem_addr, RPC);

    // PC wrap
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    peek();
    chk("wrap_pc4",   out_pc4, 32'h0);
    chk("wrap_instr", out_instr, 32'hFFFF_FFFC ^ 32'hA5A5_A5A5);
    chk("wrap_addr",  imem_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 8),
           $urandom(),
           ($urandom_range(0, 9) < 6));
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
